// File: rtl/rf_check_monitor.sv
// Hardware self-check monitor: shadows the CPU register file and walks a table of
// "flag reaches F => register R equals E" checks, reporting pass/fail/timeout.
module rf_check_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_CHECKS     = 16,
  parameter int FLAG_REG       = 20,
  parameter int TIMEOUT_CYCLES = 100,
  localparam int CW = $clog2(NUM_CHECKS),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_idx,
  input  logic [XLEN-1:0] cfg_flag,
  input  logic [4:0]      cfg_reg,
  input  logic [XLEN-1:0] cfg_exp,
  input  logic            start,
  input  logic [CW:0]     start_num,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [CW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [XLEN-1:0] fail_exp,
  output logic [TW-1:0]   cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  localparam logic [CW:0]   NUM_MAX  = (CW+1)'(NUM_CHECKS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [4:0]    FLAG_IDX = 5'(FLAG_REG);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] shadow   [32];
  logic [XLEN-1:0] tbl_flag [NUM_CHECKS];
  logic [4:0]      tbl_reg  [NUM_CHECKS];
  logic [XLEN-1:0] tbl_exp  [NUM_CHECKS];
  logic [CW-1:0]   idx;
  logic [CW:0]     num;

  logic            idle_like;
  logic            run_st;
  logic            start_ok;
  logic [CW:0]     num_clamp;
  logic [XLEN-1:0] chk_got;
  logic            flag_hit;
  logic            chk_ok;
  logic            last_ent;
  logic            next_same;
  logic            tmo_hit;

  assign idle_like = (state == S_IDLE) || (state == S_PASS) ||
                     (state == S_FAIL) || (state == S_TIMEOUT);
  assign run_st    = (state == S_ARMED) || (state == S_CHECK);
  assign start_ok  = idle_like && start;
  assign num_clamp = (start_num > NUM_MAX) ? NUM_MAX : start_num;
  assign chk_got   = shadow[tbl_reg[idx]];
  assign flag_hit  = (shadow[FLAG_IDX] == tbl_flag[idx]);
  assign chk_ok    = (chk_got == tbl_exp[idx]);
  assign last_ent  = ({1'b0, idx} == (num - (CW+1)'(1)));
  assign next_same = (tbl_flag[idx + CW'(1)] == tbl_flag[idx]);
  assign tmo_hit   = (cycles == TMO_LAST);

  // Shadow register file; x0 is never written so it reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) shadow[r] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      shadow[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && idle_like) begin
      tbl_flag[cfg_idx] <= cfg_flag;
      tbl_reg[cfg_idx]  <= cfg_reg;
      tbl_exp[cfg_idx]  <= cfg_exp;
    end
  end

  // A verdict in CHECK outranks the timeout; ARMED has no verdict to offer
  always_comb begin
    state_nxt = state;
    case (state)
      S_ARMED: begin
        if (tmo_hit)       state_nxt = S_TIMEOUT;
        else if (flag_hit) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!chk_ok)        state_nxt = S_FAIL;
        else if (last_ent)  state_nxt = S_PASS;
        else if (tmo_hit)   state_nxt = S_TIMEOUT;
        else if (!next_same) state_nxt = S_ARMED;
      end
      default: begin
        if (start) state_nxt = (num_clamp == '0) ? S_PASS : S_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      num      <= '0;
      cycles   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      fail_idx <= '0;
      fail_got <= '0;
      fail_exp <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == S_ARMED) || (state_nxt == S_CHECK);
      done    <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) ||
                 (state_nxt == S_TIMEOUT);
      pass    <= (state_nxt == S_PASS);
      fail    <= (state_nxt == S_FAIL);
      timeout <= (state_nxt == S_TIMEOUT);

      if (start_ok) begin
        num      <= num_clamp;
        idx      <= '0;
        cycles   <= '0;
        fail_idx <= '0;
        fail_got <= '0;
        fail_exp <= '0;
      end

      if (run_st && (cycles != TMO_MAX)) cycles <= cycles + TW'(1);

      if ((state == S_CHECK) && chk_ok && !last_ent && !tmo_hit) idx <= idx + CW'(1);

      if ((state == S_CHECK) && !chk_ok) begin
        fail_idx <= idx;
        fail_got <= chk_got;
        fail_exp <= tbl_exp[idx];
      end
    end
  end

endmodule

// File: tb/tb_rf_check_monitor.sv
// Bench for rf_check_monitor: directed and random runs checked against an
// edge-indexed reference model of check progress and register visibility.
module tb_rf_check_monitor;

  localparam int T  = 100;
  localparam int NC = 16;
  localparam int L  = T + 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_flag;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_exp;
  logic        start;
  logic [4:0]  start_num;
  logic        busy, done, pass, fail, timeout;
  logic [3:0]  fail_idx;
  logic [31:0] fail_got, fail_exp;
  logic [6:0]  cycles;

  rf_check_monitor #(
    .XLEN(32), .NUM_CHECKS(NC), .FLAG_REG(20), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_flag(cfg_flag),
    .cfg_reg(cfg_reg), .cfg_exp(cfg_exp),
    .start(start), .start_num(start_num),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .fail_got(fail_got), .fail_exp(fail_exp),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Reference state: shadow contents before a run, the check table, and the
  // in-run write schedule (edges counted from the start edge, ascending).
  logic [31:0] m_sh   [32];
  logic [31:0] m_flag [NC];
  logic [4:0]  m_reg  [NC];
  logic [31:0] m_exp  [NC];
  int          ws_n = 0;
  int          ws_edge [32];
  logic [4:0]  ws_reg  [32];
  logic [31:0] ws_val  [32];
  int          restart_edge = -1;
  int          cfgbusy_edge = -1;

  int          e_kind, e_c, e_fidx;
  logic [31:0] e_fgot, e_fexp;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Register value the monitor can see when deciding at edge c
  function automatic logic [31:0] vis(input int c, input logic [4:0] r);
    logic [31:0] v;
    if (r == 5'd0) return 32'd0;
    v = m_sh[r];
    for (int k = 0; k < ws_n; k++)
      if (ws_edge[k] < c && ws_reg[k] == r) v = ws_val[k];
    return v;
  endfunction

  task automatic predict(input int n);
    int i;
    bit waiting_check;
    e_kind = 0; e_c = 0; e_fidx = 0; e_fgot = 0; e_fexp = 0;
    if (n == 0) return;
    i = 0;
    waiting_check = 0;
    for (int c = 1; c <= T; c++) begin
      e_c = c;
      if (!waiting_check) begin
        if (c == T) begin e_kind = 2; return; end
        waiting_check = (vis(c, 5'd20) == m_flag[i]);
      end else if (vis(c, m_reg[i]) != m_exp[i]) begin
        e_kind = 1; e_fidx = i; e_fgot = vis(c, m_reg[i]); e_fexp = m_exp[i];
        return;
      end else if (i == n - 1) begin
        e_kind = 0; return;
      end else if (c == T) begin
        e_kind = 2; return;
      end else begin
        waiting_check = (m_flag[i+1] == m_flag[i]);
        i++;
      end
    end
  endtask

  task automatic sched(input int e, input logic [4:0] r, input logic [31:0] v);
    ws_edge[ws_n] = e; ws_reg[ws_n] = r; ws_val[ws_n] = v;
    ws_n++;
  endtask

  task automatic rf_write(input logic [4:0] r, input logic [31:0] v);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = r; rf_wdata = v;
    if (r != 5'd0) m_sh[r] = v;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  task automatic cfg_load(input int i, input logic [31:0] f, input logic [4:0] r,
                          input logic [31:0] e);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'(i); cfg_flag = f; cfg_reg = r; cfg_exp = e;
    m_flag[i] = f; m_reg[i] = r; m_exp[i] = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic apply_edge(input int e);
    rf_we = 1'b0;
    for (int k = 0; k < ws_n; k++)
      if (ws_edge[k] == e) begin
        rf_we = 1'b1; rf_waddr = ws_reg[k]; rf_wdata = ws_val[k];
      end
    if (e == restart_edge) begin start = 1'b1; start_num = 5'd0; end
    if (e == cfgbusy_edge) begin
      cfg_we = 1'b1; cfg_idx = 4'd2; cfg_flag = 32'h5a5a; cfg_reg = 5'd3; cfg_exp = 32'hdead;
    end
  endtask

  task automatic run(input string name, input int num_raw);
    int n;
    int k;
    n = (num_raw > NC) ? NC : num_raw;
    predict(n);
    @(negedge clk);
    start = 1'b1; start_num = 5'(num_raw); cfg_we = 1'b0;
    apply_edge(0);
    for (int e = 1; e <= L; e++) begin
      @(negedge clk);
      k = e - 1;
      if (k == 0) chk({name, ":busy_after_start"}, 32'(busy), 32'(n > 0));
      if (n > 0 && k == e_c - 1) chk({name, ":done_before_verdict"}, 32'(done), 32'd0);
      if (k == e_c || k == L - 1) begin
        chk({name, ":done"}, 32'(done), 32'd1);
        chk({name, ":busy"}, 32'(busy), 32'd0);
        chk({name, ":pass"}, 32'(pass), 32'(e_kind == 0));
        chk({name, ":fail"}, 32'(fail), 32'(e_kind == 1));
        chk({name, ":timeout"}, 32'(timeout), 32'(e_kind == 2));
        chk({name, ":cycles"}, 32'(cycles), 32'(e_c));
        chk({name, ":fail_idx"}, 32'(fail_idx), 32'(e_fidx));
        chk({name, ":fail_got"}, fail_got, e_fgot);
        chk({name, ":fail_exp"}, fail_exp, e_fexp);
      end
      start = 1'b0; cfg_we = 1'b0;
      apply_edge(e);
    end
    @(negedge clk);
    rf_we = 1'b0;
    for (int j = 0; j < ws_n; j++)
      if (ws_reg[j] != 5'd0) m_sh[ws_reg[j]] = ws_val[j];
    ws_n = 0; restart_edge = -1; cfgbusy_edge = -1;
  endtask

  task automatic rand_run(input int id);
    int n, g, e;
    logic [31:0] fl;
    n = $urandom_range(1, 5);
    fl = 32'h100 + 32'(id * 16);
    g = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 1) == 1) g++;
      cfg_load(i, fl + 32'(g), 5'($urandom_range(1, 19)), 32'($urandom_range(0, 3)));
    end
    e = 1;
    for (int i = 0; i < n; i++) begin
      sched(e, m_reg[i], ($urandom_range(0, 5) == 0) ? (m_exp[i] ^ 32'd1) : m_exp[i]);
      e += $urandom_range(1, 3);
      if (i == n - 1 || m_flag[i+1] != m_flag[i]) begin
        sched(e, 5'd20, m_flag[i]);
        e += $urandom_range(1, 3);
      end
    end
    run("random", n);
  endtask

  initial begin
    rst = 1'b1; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_flag = '0; cfg_reg = '0; cfg_exp = '0;
    start = 1'b0; start_num = '0;
    for (int r = 0; r < 32; r++) m_sh[r] = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:done", 32'(done), 32'd0);
    chk("reset:pass", 32'(pass), 32'd0);
    chk("reset:fail", 32'(fail), 32'd0);
    chk("reset:timeout", 32'(timeout), 32'd0);
    chk("reset:cycles", 32'(cycles), 32'd0);
    chk("reset:fail_idx", 32'(fail_idx), 32'd0);
    chk("reset:fail_got", fail_got, 32'd0);
    chk("reset:fail_exp", fail_exp, 32'd0);

    // Grouped table pass, with a stray start and table write while busy
    cfg_load(0, 32'd1, 5'd1, 32'd300);
    cfg_load(1, 32'd2, 5'd1, 32'd500);
    cfg_load(2, 32'd2, 5'd2, 32'd100);
    sched(1, 5'd1, 32'd300); sched(2, 5'd20, 32'd1); sched(6, 5'd1, 32'd500);
    sched(7, 5'd2, 32'd100); sched(8, 5'd20, 32'd2);
    restart_edge = 3; cfgbusy_edge = 4;
    run("group_pass", 3);

    sched(1, 5'd1, 32'd300); sched(2, 5'd20, 32'd1); sched(6, 5'd1, 32'd500);
    sched(7, 5'd2, 32'd99); sched(8, 5'd20, 32'd2);
    run("group_fail", 3);

    run("flag_never", 3);
    run("empty_table", 0);

    for (int i = 0; i < NC; i++) cfg_load(i, 32'd2, 5'd2, 32'd99);
    run("clamp_num", 20);

    // Verdict on the last allowed cycle beats the timeout; one cycle later it cannot
    cfg_load(0, 32'd7, 5'd3, 32'h33);
    rf_write(5'd3, 32'h33);
    sched(98, 5'd20, 32'd7); sched(100, 5'd3, 32'hbad);
    run("verdict_at_limit", 1);
    rf_write(5'd20, 32'd0);
    sched(99, 5'd20, 32'd7);
    run("flag_at_limit", 1);

    // Abort from ARMED, then a clean rerun relying on the cleared shadow
    cfg_load(0, 32'h77, 5'd1, 32'd0);
    @(negedge clk);
    start = 1'b1; start_num = 5'd1;
    @(negedge clk);
    start = 1'b0;
    chk("abort:busy_before", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort:busy", 32'(busy), 32'd0);
    chk("abort:done", 32'(done), 32'd0);
    chk("abort:cycles", 32'(cycles), 32'd0);
    chk("abort:pass", 32'(pass), 32'd0);
    for (int r = 0; r < 32; r++) m_sh[r] = 32'd0;
    rf_write(5'd0, 32'd5);
    cfg_load(0, 32'd0, 5'd0, 32'd0);
    cfg_load(1, 32'd0, 5'd1, 32'd0);
    run("rerun_x0", 2);

    for (int id = 0; id < 4; id++) rand_run(id);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
